// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared state encoding, UART framing and ASCII constants for reg_dump_uart
package reg_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        NEXT,
        FIN
    } state_t;

    localparam int         DEFAULT_CLK_DIV = 434;
    localparam int         FRAME_BITS      = 10;
    localparam logic       START_BIT       = 1'b0;
    localparam logic       STOP_BIT        = 1'b1;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASCII_0 + {4'h0, nib};
        else
            return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte transmitter; ready in the last stop-bit cycle allows gapless frames
module uart_tx_byte
    import reg_dump_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
    localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

    logic [CW-1:0] baud_cnt;
    logic [9:0]    shreg;
    logic [3:0]    bit_idx;
    logic          active;

    // The line is the LSB of the shift register; idle shifts in stop-level ones.
    assign tx    = shreg[0];
    assign ready = !active || (bit_idx == LAST_BIT && baud_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            shreg    <= '1;
            bit_idx  <= '0;
            active   <= 1'b0;
        end else if (valid && ready) begin
            shreg    <= {STOP_BIT, data, START_BIT};
            baud_cnt <= RELOAD;
            bit_idx  <= '0;
            active   <= 1'b1;
        end else if (active) begin
            if (baud_cnt == '0) begin
                baud_cnt <= RELOAD;
                shreg    <= {STOP_BIT, shreg[9:1]};
                if (bit_idx == LAST_BIT)
                    active <= 1'b0;
                else
                    bit_idx <= bit_idx + 4'd1;
            end else begin
                baud_cnt <= baud_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_dump_uart.sv
// rtl/reg_dump_uart.sv - register-file dump over UART; REG_DUMP_HEX_EN selects ASCII hex lines
module reg_dump_uart
    import reg_dump_pkg::*;
#(
    parameter int CLK_DIV  = DEFAULT_CLK_DIV,
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

`ifdef REG_DUMP_HEX_EN
    localparam int BYTES_PER_REG = 10;
`else
    localparam int BYTES_PER_REG = 4;
`endif
    localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_REG - 1);
    localparam logic [4:0] LAST_ADDR = 5'(NUM_REGS - 1);

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [3:0] idx);
`ifdef REG_DUMP_HEX_EN
        logic [4:0] sh;
        sh = 5'd28 - {idx[2:0], 2'b00};
        case (idx)
            4'd8:    return ASCII_CR;
            4'd9:    return ASCII_LF;
            default: return hex_ascii(w[sh +: 4]);
        endcase
`else
        case (idx)
            4'd0:    return w[31:24];
            4'd1:    return w[23:16];
            4'd2:    return w[15:8];
            default: return w[7:0];
        endcase
`endif
    endfunction

    state_t      state;
    logic [31:0] word;
    logic [3:0]  byte_idx;
    logic        uart_valid;
    logic        uart_ready;
    logic [7:0]  uart_data;

    // Byte 0 is taken straight from the read port in LOAD so the start bit lands on the LOAD edge.
    always_comb begin
        uart_valid = 1'b0;
        uart_data  = byte_sel(word, byte_idx + 4'd1);
        case (state)
            LOAD: begin
                uart_valid = 1'b1;
                uart_data  = byte_sel(dbg_data, 4'd0);
            end
            SEND: uart_valid = uart_ready && (byte_idx != LAST_BYTE);
            default: uart_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dbg_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            word     <= '0;
            byte_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        state    <= FETCH;
                        dbg_addr <= '0;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    word     <= dbg_data;
                    byte_idx <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    // The per-register decision folds into the final stop-bit cycle.
                    if (uart_ready) begin
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + 4'd1;
                        end else if (dbg_addr == LAST_ADDR) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            dbg_addr <= dbg_addr + 5'd1;
                            state    <= FETCH;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (uart_data),
        .valid (uart_valid),
        .ready (uart_ready),
        .tx    (tx)
    );

endmodule
